// File: rtl/detector_arbiter.sv
// Round-robin arbiter sharing one Mealy/Moore detector pair between two symbol requesters.
// Detectors are cleared at the start of every frame; Moore hits are counted per requester.
//
// state | meaning
// IDLE  | no grant; pick a requester (round-robin on a tie)
// CLEAR | one cycle holding the shared detectors in reset
// RUN   | forward the granted requester's symbols, up to FRAME_LEN
// FLUSH | one idle symbol so the Moore response to the last symbol is counted
module detector_arbiter #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [1:0]       Sym0,
    output logic             Ack0,
    input  logic             Req1,
    input  logic [1:0]       Sym1,
    output logic             Ack1,
    output logic             Det_Rst,
    output logic [1:0]       Det_Din,
    input  logic             Det_Mealy,
    input  logic             Det_Moore,
    output logic [1:0]       Gnt,
    output logic [CNT_W-1:0] Hit0,
    output logic [CNT_W-1:0] Hit1,
    output logic             Err
);

    localparam int              SC_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [SC_W-1:0] LAST    = SC_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [SC_W-1:0] sym_cnt, sym_cnt_nxt;
    logic [1:0]      gnt_nxt;
    logic            last_served, last_nxt;
    logic            req_g;
    logic [1:0]      sym_g;
    logic            consume;
    logic            mealy_d;
    logic            chk_v;
    logic            count_win;

    assign req_g     = (Gnt[0] & Req0) | (Gnt[1] & Req1);
    assign sym_g     = Gnt[1] ? Sym1 : Sym0;
    assign consume   = (state == RUN) & req_g;
    assign count_win = (state == RUN) | (state == FLUSH);
    assign Det_Rst   = Reset & (state != CLEAR);

    always_comb begin
        state_nxt   = state;
        sym_cnt_nxt = sym_cnt;
        gnt_nxt     = Gnt;
        last_nxt    = last_served;
        Ack0        = 1'b0;
        Ack1        = 1'b0;
        Det_Din     = 2'b00;
        case (state)
            IDLE: begin
                gnt_nxt = 2'b00;
                // On a tie, requester 0 wins only if requester 1 was served last
                if (Req0 && (!Req1 || last_served)) begin
                    gnt_nxt   = 2'b01;
                    last_nxt  = 1'b0;
                    state_nxt = CLEAR;
                end else if (Req1) begin
                    gnt_nxt   = 2'b10;
                    last_nxt  = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                sym_cnt_nxt = '0;
                state_nxt   = RUN;
            end
            RUN: begin
                if (consume) begin
                    Ack0    = Gnt[0];
                    Ack1    = Gnt[1];
                    Det_Din = sym_g;
                    if (sym_cnt == LAST) state_nxt = FLUSH;
                    else                 sym_cnt_nxt = sym_cnt + 1'b1;
                end else begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                gnt_nxt   = 2'b00;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            sym_cnt     <= '0;
            Gnt         <= 2'b00;
            last_served <= 1'b1;
            Hit0        <= '0;
            Hit1        <= '0;
            mealy_d     <= 1'b0;
            chk_v       <= 1'b0;
            Err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            sym_cnt     <= sym_cnt_nxt;
            Gnt         <= gnt_nxt;
            last_served <= last_nxt;
            if (count_win && Det_Moore && Gnt[0] && (Hit0 != CNT_MAX)) Hit0 <= Hit0 + 1'b1;
            if (count_win && Det_Moore && Gnt[1] && (Hit1 != CNT_MAX)) Hit1 <= Hit1 + 1'b1;
            // Moore lags Mealy by one symbol, so compare last cycle's Mealy with Moore now
            if (consume) mealy_d <= Det_Mealy;
            chk_v <= consume;
            Err   <= chk_v & (mealy_d != Det_Moore);
        end
    end

endmodule

// File: tb/tb_detector_arbiter.sv
// Directed bench for detector_arbiter with a behavioural detector pair (hit on symbol 3).
// A second instance with CNT_W=2 shares the stimulus to observe counter saturation.
module tb_detector_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Req0, Req1;
    logic [1:0] Sym0, Sym1;
    logic       Ack0, Ack1, Det_Rst, Err;
    logic [1:0] Det_Din, Gnt;
    logic [7:0] Hit0, Hit1;
    logic       det_mealy, det_moore;

    logic       s_ack0, s_ack1, s_det_rst, s_err;
    logic [1:0] s_det_din, s_gnt, s_hit0, s_hit1;

    int checks   = 0;
    int failures = 0;
    int moore_events = 0;
    int drop_at = -1;

    always #5 Clk = ~Clk;

    detector_arbiter #(.FRAME_LEN(8), .CNT_W(8)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Sym0(Sym0), .Ack0(Ack0),
        .Req1(Req1), .Sym1(Sym1), .Ack1(Ack1),
        .Det_Rst(Det_Rst), .Det_Din(Det_Din),
        .Det_Mealy(det_mealy), .Det_Moore(det_moore),
        .Gnt(Gnt), .Hit0(Hit0), .Hit1(Hit1), .Err(Err)
    );

    detector_arbiter #(.FRAME_LEN(8), .CNT_W(2)) u_dut_sat (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Sym0(Sym0), .Ack0(s_ack0),
        .Req1(Req1), .Sym1(Sym1), .Ack1(s_ack1),
        .Det_Rst(s_det_rst), .Det_Din(s_det_din),
        .Det_Mealy(det_mealy), .Det_Moore(det_moore),
        .Gnt(s_gnt), .Hit0(s_hit0), .Hit1(s_hit1), .Err(s_err)
    );

    // Detector model: Mealy flags symbol 3 immediately, Moore one cycle later.
    // drop_at suppresses one chosen Moore hit to create a disagreement.
    assign det_mealy = (Det_Din == 2'b11);

    always @(posedge Clk) begin
        if (!Det_Rst) begin
            det_moore <= 1'b0;
        end else if (Det_Din == 2'b11) begin
            det_moore    <= (moore_events != drop_at);
            moore_events <= moore_events + 1;
        end else begin
            det_moore <= 1'b0;
        end
    end

    task automatic nxt;
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset;
        Reset = 1'b0;
        Req0 = 1'b0; Req1 = 1'b0; Sym0 = 2'b00; Sym1 = 2'b00;
        repeat (3) nxt;
        Reset = 1'b1;
    endtask

    // Runs one full frame from IDLE back to IDLE; cycle 0 is CLEAR, 1..8 RUN, 9 FLUSH, 10 IDLE
    task automatic drive_frame(input logic [1:0] syms [8], input int who,
                               output int acks, output int errs, output int err_cyc);
        acks = 0; errs = 0; err_cyc = -1;
        Req0 = (who == 0);
        Req1 = (who == 1);
        for (int c = 0; c <= 10; c++) begin
            nxt;
            if (c >= 1 && c <= 8) begin
                if (who == 0) Sym0 = syms[c-1];
                else          Sym1 = syms[c-1];
            end else begin
                Sym0 = 2'b00; Sym1 = 2'b00;
            end
            if (c == 9) begin Req0 = 1'b0; Req1 = 1'b0; end
            #1;
            if ((who == 0) ? Ack0 : Ack1) acks++;
            if (Err) begin
                errs++;
                if (err_cyc < 0) err_cyc = c;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Sym0 = 2'b01; Sym1 = 2'b10;
        repeat (3) nxt;
        checks++; if (Gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", Gnt); end
        checks++; if ({Ack1, Ack0} !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", {Ack1, Ack0}); end
        checks++; if (Det_Rst !== 1'b0) begin failures++; $display("FAIL reset_det_rst got=%b exp=0", Det_Rst); end
        checks++; if (Det_Din !== 2'b00) begin failures++; $display("FAIL reset_det_din got=%b exp=00", Det_Din); end
        checks++; if (Hit0 !== 8'd0 || Hit1 !== 8'd0) begin failures++; $display("FAIL reset_hits got=%0d/%0d exp=0/0", Hit0, Hit1); end
        checks++; if (Err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", Err); end
        Reset = 1'b1;
        nxt;
        checks++; if (Gnt !== 2'b01) begin failures++; $display("FAIL reset_first_tie got=%b exp=01", Gnt); end
        repeat (3) nxt;
        Reset = 1'b0;
        nxt;
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        #1;
        checks++; if (Gnt !== 2'b00 || Ack0 !== 1'b0) begin failures++; $display("FAIL reset_mid_frame gnt=%b ack0=%b exp=00/0", Gnt, Ack0); end
    endtask

    task automatic test_single_frame;
        int acks;
        apply_reset;
        Req0 = 1'b1; Sym0 = 2'b01;
        #1;
        checks++; if (Gnt !== 2'b00) begin failures++; $display("FAIL single_idle_gnt got=%b exp=00", Gnt); end
        nxt;
        checks++; if (Gnt !== 2'b01 || Det_Rst !== 1'b0 || Ack0 !== 1'b0) begin
            failures++; $display("FAIL single_clear gnt=%b det_rst=%b ack0=%b exp=01/0/0", Gnt, Det_Rst, Ack0); end
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            nxt;
            if (Ack0 === 1'b1 && Ack1 === 1'b0 && Det_Rst === 1'b1 && Det_Din === 2'b01) acks++;
        end
        checks++; if (acks != 8) begin failures++; $display("FAIL single_acks got=%0d exp=8", acks); end
        nxt;
        checks++; if (Ack0 !== 1'b0 || Gnt !== 2'b01 || Det_Din !== 2'b00) begin
            failures++; $display("FAIL single_flush ack0=%b gnt=%b din=%b exp=0/01/00", Ack0, Gnt, Det_Din); end
        nxt;
        checks++; if (Gnt !== 2'b00) begin failures++; $display("FAIL single_turn_idle got=%b exp=00", Gnt); end
        nxt;
        checks++; if (Gnt !== 2'b01) begin failures++; $display("FAIL single_regrant got=%b exp=01", Gnt); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_gnt;
        int a0, a1, bad_din, both;
        apply_reset;
        Req0 = 1'b1; Req1 = 1'b1; Sym0 = 2'b01; Sym1 = 2'b10;
        for (int f = 0; f < 4; f++) begin
            exp_gnt = (f % 2 == 0) ? 2'b01 : 2'b10;
            nxt;
            checks++; if (Gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt frame=%0d got=%b exp=%b", f, Gnt, exp_gnt); end
            a0 = 0; a1 = 0; bad_din = 0; both = 0;
            for (int i = 0; i < 8; i++) begin
                nxt;
                if (Ack0 === 1'b1) a0++;
                if (Ack1 === 1'b1) a1++;
                if (Ack0 === 1'b1 && Ack1 === 1'b1) both++;
                if (Det_Din !== ((f % 2 == 0) ? 2'b01 : 2'b10)) bad_din++;
            end
            checks++; if (((f % 2 == 0) ? a0 : a1) != 8 || ((f % 2 == 0) ? a1 : a0) != 0 || both != 0) begin
                failures++; $display("FAIL rr_acks frame=%0d ack0=%0d ack1=%0d both=%0d", f, a0, a1, both); end
            checks++; if (bad_din != 0) begin failures++; $display("FAIL rr_din frame=%0d bad=%0d exp=0", f, bad_din); end
            nxt;
            nxt;
        end
    endtask

    task automatic test_abort;
        int acks;
        apply_reset;
        Req1 = 1'b1; Sym1 = 2'b10;
        Req0 = 1'b0;
        nxt;
        checks++; if (Gnt !== 2'b10) begin failures++; $display("FAIL abort_gnt got=%b exp=10", Gnt); end
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            nxt;
            Req0 = ~Req0;
            #1;
            if (Ack1 === 1'b1 && Ack0 === 1'b0) acks++;
        end
        nxt;
        Req1 = 1'b0; Req0 = 1'b0;
        #1;
        checks++; if (Ack1 !== 1'b0 || Det_Din !== 2'b00) begin
            failures++; $display("FAIL abort_drop ack1=%b din=%b exp=0/00", Ack1, Det_Din); end
        nxt;
        if (Ack1 === 1'b1) acks++;
        checks++; if (acks != 3) begin failures++; $display("FAIL abort_acks got=%0d exp=3", acks); end
        checks++; if (Gnt !== 2'b10) begin failures++; $display("FAIL abort_flush_gnt got=%b exp=10", Gnt); end
        nxt;
        checks++; if (Gnt !== 2'b00) begin failures++; $display("FAIL abort_idle_gnt got=%b exp=00", Gnt); end
    endtask

    task automatic test_hits;
        logic [1:0] s [8];
        int acks, errs, ecyc;
        apply_reset;
        s = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0};
        drive_frame(s, 0, acks, errs, ecyc);
        checks++; if (Hit0 !== 8'd3 || Hit1 !== 8'd0) begin failures++; $display("FAIL hits_f1 got=%0d/%0d exp=3/0", Hit0, Hit1); end
        checks++; if (s_hit0 !== 2'd3) begin failures++; $display("FAIL hits_sat_f1 got=%0d exp=3", s_hit0); end
        checks++; if (acks != 8 || errs != 0) begin failures++; $display("FAIL hits_f1_acks_err acks=%0d errs=%0d exp=8/0", acks, errs); end
        s = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3};
        drive_frame(s, 0, acks, errs, ecyc);
        checks++; if (Hit0 !== 8'd8 || Hit1 !== 8'd0) begin failures++; $display("FAIL hits_f2 got=%0d/%0d exp=8/0", Hit0, Hit1); end
        checks++; if (s_hit0 !== 2'd3) begin failures++; $display("FAIL hits_sat_f2 got=%0d exp=3", s_hit0); end
        checks++; if (errs != 0) begin failures++; $display("FAIL hits_f2_err got=%0d exp=0", errs); end
        s = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
        drive_frame(s, 1, acks, errs, ecyc);
        checks++; if (Hit0 !== 8'd8 || Hit1 !== 8'd2) begin failures++; $display("FAIL hits_f3 got=%0d/%0d exp=8/2", Hit0, Hit1); end
    endtask

    task automatic test_mismatch;
        logic [1:0] s [8];
        int acks, errs, ecyc;
        apply_reset;
        drop_at = moore_events + 1;
        s = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        drive_frame(s, 0, acks, errs, ecyc);
        drop_at = -1;
        checks++; if (errs != 1) begin failures++; $display("FAIL mismatch_pulses got=%0d exp=1", errs); end
        checks++; if (ecyc != 5) begin failures++; $display("FAIL mismatch_timing got=%0d exp=5", ecyc); end
        checks++; if (Hit0 !== 8'd1) begin failures++; $display("FAIL mismatch_hit0 got=%0d exp=1", Hit0); end
        s = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        drive_frame(s, 0, acks, errs, ecyc);
        checks++; if (errs != 0) begin failures++; $display("FAIL match_no_err got=%0d exp=0", errs); end
        checks++; if (Hit0 !== 8'd3) begin failures++; $display("FAIL match_hit0 got=%0d exp=3", Hit0); end
    endtask

    initial begin
        Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Sym0 = 2'b00; Sym1 = 2'b00;
        test_reset;
        test_single_frame;
        test_round_robin;
        test_abort;
        test_hits;
        test_mismatch;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
